// File: rtl/div_rem_unit_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
// The master side issues operand pairs; the slave side (the divider) reports status and the result.
interface div_rem_unit_if #(
  parameter int DATA_W = 32
);
  logic              Start;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [1:0]        Op;
  logic              Busy;
  logic              Done;
  logic [DATA_W-1:0] Result;

  modport master (
    output Start, A, B, Op,
    input  Busy, Done, Result
  );

  modport slave (
    input  Start, A, B, Op,
    output Busy, Done, Result
  );
endinterface

// File: rtl/div_rem_unit.sv
// Restoring radix-2 divider for DIV/DIVU/REM/REMU with a fixed DATA_W+2 cycle latency.
// Signed ops divide magnitudes and fix signs afterwards; RISC-V special cases are resolved at accept.
module div_rem_unit #(
  parameter int DATA_W = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  div_rem_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic              signA_q, signA_d;
  logic              signB_q, signB_d;
  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              special_q, special_d;
  logic [DATA_W-1:0] specVal_q, specVal_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic              busy, done;
  logic              signedIn, divZero, overflow;
  logic [DATA_W+1:0] remShift;
  logic [DATA_W+2:0] trial;
  logic              borrow;
  logic [DATA_W-1:0] quoFix, remFix;

  // One restoring step: the top bit of trial is the borrow of the shifted remainder minus the divisor
  always_comb begin
    signedIn = ~bus.Op[0];
    divZero  = (bus.B == '0);
    overflow = signedIn && (bus.A == MIN_NEG) && (bus.B == '1);
    remShift = {rem_q, quo_q[DATA_W-1]};
    trial    = {1'b0, remShift} - {3'b000, divisor_q};
    borrow   = trial[DATA_W+2];
    quoFix   = (~op_q[0] && (signA_q != signB_q)) ? -quo_q : quo_q;
    remFix   = (~op_q[0] && signA_q) ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    signA_d   = signA_q;
    signB_d   = signB_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    count_d   = count_q;
    special_d = special_q;
    specVal_d = specVal_q;
    result_d  = result_q;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d   = CALC;
          op_d      = bus.Op;
          signA_d   = bus.A[DATA_W-1];
          signB_d   = bus.B[DATA_W-1];
          quo_d     = (signedIn && bus.A[DATA_W-1]) ? -bus.A : bus.A;
          divisor_d = (signedIn && bus.B[DATA_W-1]) ? -bus.B : bus.B;
          rem_d     = '0;
          count_d   = '0;
          special_d = divZero || overflow;
          if (divZero) begin
            specVal_d = bus.Op[1] ? bus.A : '1;
          end else begin
            specVal_d = bus.Op[1] ? '0 : MIN_NEG;
          end
        end
      end
      CALC: begin
        busy    = 1'b1;
        rem_d   = borrow ? remShift[DATA_W:0] : trial[DATA_W:0];
        quo_d   = {quo_q[DATA_W-2:0], ~borrow};
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          state_d = FIX;
        end
      end
      FIX: begin
        busy     = 1'b1;
        result_d = special_q ? specVal_q : (op_q[1] ? remFix : quoFix);
        state_d  = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      count_q   <= '0;
      special_q <= 1'b0;
      specVal_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      signA_q   <= signA_d;
      signB_q   <= signB_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      count_q   <= count_d;
      special_q <= special_d;
      specVal_q <= specVal_d;
      result_q  <= result_d;
    end
  end

  assign bus.Busy   = busy;
  assign bus.Done   = done;
  assign bus.Result = result_q;

endmodule
